xbus_decoder: RTL and testbench
===============================

XBUS_DECODER -- requirements
Module: xbus_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, master address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter N_SLV, default 4, slave channel count (1..16).
REQ-004 SHALL have parameter SLV_BASE, default 0, N_SLV*ADDR_W flattened base vector, slave i at bits [i*ADDR_W +: ADDR_W].
REQ-005 SHALL have parameter SLV_MASK, default 0, N_SLV*ADDR_W flattened mask vector; 1 = compared bit.
REQ-006 SHALL have parameter TMO_CYC, default 255, max wait cycles before timeout (8-bit counter).
REQ-007 SHALL have port clk  in  1  sole clock, rising edge.
REQ-008 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port addr  in  ADDR_W  master address.
REQ-010 SHALL have port sel  in  1  master request; held with addr until ready.
REQ-011 SHALL have port ready  out  1  one-cycle response strobe.
REQ-012 SHALL have port data_to_rd  out  DATA_W  response data, valid with ready.
REQ-013 SHALL have port slv_sel  out  N_SLV  one-hot slave select.
REQ-014 SHALL have port slv_ready  in  N_SLV  per-slave completion.
REQ-015 SHALL have port slv_data  in  N_SLV*DATA_W  flattened slave read data.
REQ-016 SHALL have ports trap  out  1  sticky error flag; trap_addr  out  ADDR_W  faulting address; trap_clr  in  1  clears trap.

Function
REQ-017 SHALL decode: slave i hits when (addr & SLV_MASK[i]) == SLV_BASE[i]; lowest hitting index wins.
REQ-018 SHALL implement FSM IDLE, ACCESS, RESP, ERR.
REQ-019 In IDLE with sel=1 and a hit, SHALL register index and addr, go to ACCESS.
REQ-020 In IDLE with sel=1 and no hit, SHALL go to ERR.
REQ-021 In ACCESS, slv_sel SHALL be one-hot on the registered index, all others 0.
REQ-022 In ACCESS with slv_ready[idx]=1, SHALL register slv_data[idx], drop slv_sel next cycle, go to RESP; slv_ready of non-selected slaves ignored.
REQ-023 In RESP, ready=1 and data_to_rd=registered data for exactly one cycle, then IDLE.
REQ-024 Minimum latency SHALL be sel rising (cycle 0) -> ready in cycle 2 when slave responds in cycle 1.
REQ-025 In ERR, ready=1 and data_to_rd=0 for one cycle, trap set, trap_addr loaded with the captured address, then IDLE.
REQ-026 data_to_rd SHALL be 0 whenever ready=0.
REQ-027 sel SHALL be ignored outside IDLE; back-to-back requests are accepted in the cycle after RESP/ERR.
REQ-028 trap SHALL remain set until trap_clr=1; simultaneous set and trap_clr: set wins, trap_addr updated.
REQ-029 Additional faults while trap=1 SHALL NOT overwrite trap_addr (first fault kept).

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE; ready, slv_sel, data_to_rd, trap, trap_addr, timeout counter all 0.
REQ-031 Reset mid-ACCESS SHALL drop slv_sel immediately; no response is issued for the aborted request.

Configuration
REQ-032 Macro XBUS_DECODER_TIMEOUT_EN defined: counter clears on ACCESS entry, increments each ACCESS cycle; when it equals TMO_CYC without slv_ready, SHALL drop slv_sel and go to ERR.
REQ-033 Macro undefined: no counter; ACCESS waits indefinitely for slv_ready.

Structure
REQ-034 FSM state encoding and the response-data zero constant SHALL live in shared package xbus_pkg.
REQ-035 The mask/compare priority encoder SHALL be sub-module xbus_match (addr, base, mask vectors -> hit, index).

Verification
REQ-036 N_SLV=4, slave1 base 0x100 mask 0xF00; addr=0x104, slv_ready[1] in cycle 1 with data 0xCAFE -> slv_sel=0010 cycle 1, ready and data_to_rd=0xCAFE in cycle 2.
REQ-037 Overlap: slaves 0 and 2 both hit addr 0x0 -> slv_sel=0001 only.
REQ-038 Unmapped addr 0xFFF0 -> ready with data 0 cycle 1, trap=1, trap_addr=0xFFF0; second fault at 0xEEE0 leaves trap_addr=0xFFF0; trap_clr -> trap=0.
REQ-039 TIMEOUT_EN, TMO_CYC=4, slave never ready -> slv_sel high 4 cycles, then ERR response and trap=1; without macro, slv_sel remains high 100 cycles.
REQ-040 rst_n low during ACCESS -> slv_sel=0 same cycle, no ready pulse after release; next request served normally.

Source files
------------

// File: rtl/xbus_pkg.sv
// Shared definitions for the xbus address decoder: FSM state encoding,
// response-data zero constant and timeout counter width.
package xbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  localparam int unsigned DATA_W_MAX = 1024;
  localparam logic [DATA_W_MAX-1:0] RESP_ZERO = '0;

  localparam int unsigned TMO_W = 8;

endpackage

// File: rtl/xbus_match.sv
// Mask/compare address matcher with a lowest-index-wins priority encoder.
module xbus_match #(
  parameter int ADDR_W = 32,
  parameter int N_SLV  = 4,
  parameter int IDX_W  = 2
) (
  input  logic [ADDR_W-1:0]       addr,
  input  logic [N_SLV*ADDR_W-1:0] base,
  input  logic [N_SLV*ADDR_W-1:0] mask,
  output logic                    hit,
  output logic [IDX_W-1:0]        idx
);

  logic [N_SLV-1:0] hit_vec;

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_cmp
    assign hit_vec[gi] =
      ((addr & mask[gi*ADDR_W +: ADDR_W]) == base[gi*ADDR_W +: ADDR_W]);
  end

  assign hit = |hit_vec;

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    idx = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hit_vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/xbus_decoder.sv
// Single-master to N-slave address decoder with sticky error trap.
// Optional ACCESS timeout enabled by defining XBUS_DECODER_TIMEOUT_EN.
module xbus_decoder
  import xbus_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int N_SLV  = 4,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK = '0,
  parameter int TMO_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_W-1:0]       addr,
  input  logic                    sel,
  output logic                    ready,
  output logic [DATA_W-1:0]       data_to_rd,
  output logic [N_SLV-1:0]        slv_sel,
  input  logic [N_SLV-1:0]        slv_ready,
  input  logic [N_SLV*DATA_W-1:0] slv_data,
  output logic                    trap,
  output logic [ADDR_W-1:0]       trap_addr,
  input  logic                    trap_clr
);

  localparam int IDX_W = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TMO_CYC);

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    idx_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   data_reg;
  logic                trap_reg;
  logic [ADDR_W-1:0]   trap_addr_reg;

  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic                cur_ready;
  logic [DATA_W-1:0]   cur_data;
  logic                tmo;

  xbus_match #(
    .ADDR_W (ADDR_W),
    .N_SLV  (N_SLV),
    .IDX_W  (IDX_W)
  ) u_match (
    .addr (addr),
    .base (SLV_BASE),
    .mask (SLV_MASK),
    .hit  (hit),
    .idx  (hit_idx)
  );

  assign cur_ready = slv_ready[idx_reg];
  assign cur_data  = slv_data[idx_reg*DATA_W +: DATA_W];

`ifdef XBUS_DECODER_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_reg;

  // Held at zero outside ACCESS, so every ACCESS entry starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= '0;
    end else if (state_reg == ST_ACCESS) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end else begin
      tmo_cnt_reg <= '0;
    end
  end

  // Fires on the ACCESS cycle whose increment brings the count to the limit.
  assign tmo = (state_reg == ST_ACCESS) && ((tmo_cnt_reg + 1'b1) == TMO_LIM);
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_LIM;
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (sel) state_next = hit ? ST_ACCESS : ST_ERR;
      end
      ST_ACCESS: begin
        if (cur_ready)  state_next = ST_RESP;
        else if (tmo)   state_next = ST_ERR;
      end
      ST_RESP:  state_next = ST_IDLE;
      ST_ERR:   state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      addr_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && sel) begin
        idx_reg  <= hit_idx;
        addr_reg <= addr;
      end
      if (state_reg == ST_ACCESS && cur_ready) begin
        data_reg <= cur_data;
      end
    end
  end

  // A new fault beats a same-cycle clear and then counts as the first fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_reg      <= 1'b0;
      trap_addr_reg <= '0;
    end else if (state_reg == ST_ERR) begin
      trap_reg <= 1'b1;
      if (!trap_reg || trap_clr) trap_addr_reg <= addr_reg;
    end else if (trap_clr) begin
      trap_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < N_SLV; gi++) begin : g_sel
    assign slv_sel[gi] = (state_reg == ST_ACCESS) && (idx_reg == IDX_W'(gi));
  end

  assign ready      = (state_reg == ST_RESP) || (state_reg == ST_ERR);
  assign data_to_rd = (state_reg == ST_RESP) ? data_reg : RESP_ZERO[DATA_W-1:0];
  assign trap       = trap_reg;
  assign trap_addr  = trap_addr_reg;

endmodule

// File: tb/tb_xbus_decoder.sv
// Randomized self-checking bench for xbus_decoder against a table-driven
// address map and a transaction-level response/trap model.
module tb_xbus_decoder;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NS = 4;

  localparam logic [AW-1:0] BASE_TAB [NS] = '{16'h0000, 16'h0100, 16'h0000, 16'h2000};
  localparam logic [AW-1:0] MASK_TAB [NS] = '{16'hFF00, 16'hFF00, 16'hF000, 16'hF000};

  logic              clk = 1'b0;
  logic              rst_n;
  logic [AW-1:0]     addr;
  logic              sel;
  logic              ready;
  logic [DW-1:0]     data_to_rd;
  logic [NS-1:0]     slv_sel;
  logic [NS-1:0]     slv_ready;
  logic [NS*DW-1:0]  slv_data;
  logic              trap;
  logic [AW-1:0]     trap_addr;
  logic              trap_clr;

  int n_checks = 0;
  int n_errors = 0;
  logic          exp_trap;
  logic [AW-1:0] exp_trap_addr;

  xbus_decoder #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .N_SLV    (NS),
    .SLV_BASE ({16'h2000, 16'h0000, 16'h0100, 16'h0000}),
    .SLV_MASK ({16'hF000, 16'hF000, 16'hFF00, 16'hFF00}),
    .TMO_CYC  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .sel        (sel),
    .ready      (ready),
    .data_to_rd (data_to_rd),
    .slv_sel    (slv_sel),
    .slv_ready  (slv_ready),
    .slv_data   (slv_data),
    .trap       (trap),
    .trap_addr  (trap_addr),
    .trap_clr   (trap_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++) begin
      if ((a & MASK_TAB[i]) == BASE_TAB[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] r;
    r = AW'($urandom);
    case ($urandom_range(0, 4))
      0: return {8'h00, r[7:0]};
      1: return {8'h01, r[7:0]};
      2: return {4'h0, r[11:0]};
      3: return {4'h2, r[11:0]};
      default: return r;
    endcase
  endfunction

  task automatic check_trap(input string tag);
    check({tag, "_trap"}, trap, exp_trap);
    check({tag, "_trap_addr"}, trap_addr, exp_trap_addr);
  endtask

  // Called at a falling edge with the DUT idle; returns at a falling edge, idle.
  task automatic do_txn(input logic [AW-1:0] a, input int dly,
                        input logic [DW-1:0] d, input logic clr_in_err);
    int idx;
    logic [DW-1:0] exp_data;
    idx = ref_decode(a);
    exp_data = '0;
    check("idle_ready", ready, 1'b0);
    check("idle_slv_sel", slv_sel, '0);
    addr = a;
    sel  = 1'b1;
    @(negedge clk);
    if (idx < 0) begin
      check("err_ready", ready, 1'b1);
      check("err_data", data_to_rd, '0);
      check("err_slv_sel", slv_sel, '0);
      sel = 1'b0;
      trap_clr = clr_in_err;
      if (!exp_trap || clr_in_err) exp_trap_addr = a;
      exp_trap = 1'b1;
      @(negedge clk);
      trap_clr = 1'b0;
      check("err_after_ready", ready, 1'b0);
      check_trap("err");
    end else begin
      for (int k = 0; k <= dly; k++) begin
        check("acc_slv_sel", slv_sel, NS'(1) << idx);
        check("acc_ready", ready, 1'b0);
        check("acc_data_zero", data_to_rd, '0);
        slv_data  = {$urandom, $urandom};
        slv_ready = NS'($urandom) & ~(NS'(1) << idx);
        if (k == dly) begin
          slv_ready[idx] = 1'b1;
          slv_data[idx*DW +: DW] = d;
          exp_data = d;
        end
        @(negedge clk);
      end
      slv_ready = '0;
      check("resp_ready", ready, 1'b1);
      check("resp_data", data_to_rd, exp_data);
      check("resp_slv_sel", slv_sel, '0);
      sel = 1'b0;
      @(negedge clk);
      check("post_resp_ready", ready, 1'b0);
      check("post_resp_data", data_to_rd, '0);
      check_trap("hit");
    end
    $display("txn addr=%h slave=%0d dly=%0d data=%h trap=%0b trap_addr=%h",
             a, idx, dly, exp_data, trap, trap_addr);
  endtask

  task automatic pulse_clr();
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
    exp_trap = 1'b0;
    check_trap("clr");
    $display("txn trap_clr trap=%0b trap_addr=%h", trap, trap_addr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0; addr = '0; sel = 1'b0; slv_ready = '0; slv_data = '0; trap_clr = 1'b0;
    exp_trap = 1'b0; exp_trap_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b0);
    check("rst_slv_sel", slv_sel, '0);
    check("rst_data", data_to_rd, '0);
    check_trap("rst");
    rst_n = 1'b1;
    @(negedge clk);

    do_txn(16'h0104, 0, 16'hCAFE, 1'b0);
    do_txn(16'h0000, 1, 16'h1234, 1'b0);
    do_txn(16'hFFF0, 0, '0, 1'b0);
    do_txn(16'hEEE0, 0, '0, 1'b0);
    pulse_clr();
    do_txn(16'hFFF0, 0, '0, 1'b0);
    do_txn(16'hEEE0, 0, '0, 1'b1);
    pulse_clr();

    for (int t = 0; t < 150; t++) begin
      int gap;
      do_txn(rand_addr(), int'($urandom_range(0, 3)), DW'($urandom), 1'b0);
      if ($urandom_range(0, 5) == 0) pulse_clr();
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("gap_ready", ready, 1'b0);
      end
    end

    // Slave 3 never answers.
    addr = 16'h2010;
    sel  = 1'b1;
    @(negedge clk);
    cnt = 0;
    while (slv_sel == 4'b1000 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
`ifdef XBUS_DECODER_TIMEOUT_EN
    check("tmo_sel_cycles", cnt, 4);
    check("tmo_ready", ready, 1'b1);
    check("tmo_data", data_to_rd, '0);
    sel = 1'b0;
    if (!exp_trap) exp_trap_addr = 16'h2010;
    exp_trap = 1'b1;
    @(negedge clk);
    check_trap("tmo");
    $display("txn timeout addr=2010 sel_cycles=%0d trap=%0b", cnt, trap);
`else
    check("notmo_sel_cycles", cnt, 100);
    check("notmo_sel_held", slv_sel, 4'b1000);
    slv_ready = 4'b1000;
    slv_data  = {16'hBEEF, 48'h0};
    @(negedge clk);
    slv_ready = '0;
    check("notmo_resp_ready", ready, 1'b1);
    check("notmo_resp_data", data_to_rd, 16'hBEEF);
    sel = 1'b0;
    @(negedge clk);
    $display("txn no-timeout addr=2010 sel_cycles=%0d data=%h", cnt, 16'hBEEF);
`endif

    // Reset while a slave is selected.
    addr = 16'h0104;
    sel  = 1'b1;
    @(negedge clk);
    check("rstacc_sel_before", slv_sel, 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    check("rstacc_sel_dropped", slv_sel, '0);
    check("rstacc_ready", ready, 1'b0);
    exp_trap = 1'b0;
    exp_trap_addr = '0;
    check_trap("rstacc");
    sel = 1'b0;
    slv_ready = 4'b0010;
    @(negedge clk);
    rst_n = 1'b1;
    slv_ready = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstacc_no_ready", ready, 1'b0);
    end
    $display("txn reset-abort addr=0104 ready_after_release=%0b", ready);
    do_txn(16'h0104, 0, 16'hCAFE, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
